// File: rtl/switch_debouncer.sv
// switch_debouncer
// Conditions raw, bouncing slide-switch pins for the switches PIO in_port.
// Each bit passes through a two-flop synchronizer and then a stability
// counter. The clean level only flips after the synchronized input has
// disagreed with it for STABLE_CYCLES consecutive clocks. Any agreeing sample
// in between throws away all progress. Rise/fall pulses mark the first cycle
// in which a new clean level is visible.
module switch_debouncer #(
   parameter int WIDTH         = 4,
   parameter int STABLE_CYCLES = 500000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_sw_raw,
   output logic [WIDTH-1:0] o_sw_clean,
   output logic [WIDTH-1:0] o_sw_rise,
   output logic [WIDTH-1:0] o_sw_fall,
   output logic             o_sw_changed
);

   // The counter only needs to reach STABLE_CYCLES-1, so it never wraps.
   localparam int            CW      = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] LP_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] LP_ONE  = CW'(1);

   logic [WIDTH-1:0] r_s1;
   logic [WIDTH-1:0] r_s2;
   logic [WIDTH-1:0] r_clean_q;
   logic [WIDTH-1:0] w_clean;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;

   // Two-flop synchronizer on the asynchronous pins, plus the one-cycle
   // delayed copy of the clean level used for edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1      <= '0;
         r_s2      <= '0;
         r_clean_q <= '0;
      end else begin
         r_s1      <= i_sw_raw;
         r_s2      <= r_s1;
         r_clean_q <= w_clean;
      end
   end

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic [CW-1:0] r_cnt;
         logic          r_clean;

         // Per-bit stability counter: agreement clears it, a full run of
         // disagreeing samples flips the clean level and restarts the count.
         always_ff @(posedge clk) begin
            if (reset) begin
               r_cnt   <= '0;
               r_clean <= 1'b0;
            end else if (r_s2[gi] == r_clean) begin
               r_cnt   <= '0;
            end else if (r_cnt == LP_LAST) begin
               r_clean <= r_s2[gi];
               r_cnt   <= '0;
            end else begin
               r_cnt   <= r_cnt + LP_ONE;
            end
         end

         assign w_clean[gi] = r_clean;
      end
   endgenerate

   // Edges are taken between two registers, so the pulses are glitch-free
   // and there is no path from the raw pins to any output.
   assign w_rise       = w_clean & ~r_clean_q;
   assign w_fall       = ~w_clean & r_clean_q;
   assign o_sw_clean   = w_clean;
   assign o_sw_rise    = w_rise;
   assign o_sw_fall    = w_fall;
   assign o_sw_changed = |(w_rise | w_fall);

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer (WIDTH=4, STABLE_CYCLES=4).
// A window-based reference model predicts the outputs after every clock edge
// and queues them; a monitor on the falling edge pops and compares. Directed
// scenarios add fixed-value checks on latency and pulse shape.
module tb_switch_debouncer;

   localparam int W = 4;
   localparam int S = 4;

   logic         clk;
   logic         reset;
   logic [W-1:0] i_sw_raw;
   logic [W-1:0] o_sw_clean;
   logic [W-1:0] o_sw_rise;
   logic [W-1:0] o_sw_fall;
   logic         o_sw_changed;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [W-1:0] clean;
      logic [W-1:0] rise;
      logic [W-1:0] fall;
      logic         changed;
   } exp_t;

   exp_t exp_q[$];

   switch_debouncer #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_sw_raw     (i_sw_raw),
      .o_sw_clean   (o_sw_clean),
      .o_sw_rise    (o_sw_rise),
      .o_sw_fall    (o_sw_fall),
      .o_sw_changed (o_sw_changed)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: the raw input is delayed two edges; a clean bit flips
   // when the last S delayed samples since reset all differ from it.
   logic [W-1:0] m_s1 = '0;
   logic [W-1:0] m_s2 = '0;
   logic [W-1:0] m_clean = '0;
   logic [W-1:0] hist[$];

   task automatic model_step();
      logic [W-1:0] old_clean;
      logic [W-1:0] nc;
      logic         all_diff;
      exp_t         e;
      old_clean = m_clean;
      if (reset) begin
         m_s1    = '0;
         m_s2    = '0;
         m_clean = '0;
         hist.delete();
         e = '0;
      end else begin
         hist.push_back(m_s2);
         if (hist.size() > S) void'(hist.pop_front());
         nc = m_clean;
         for (int b = 0; b < W; b++) begin
            if (hist.size() == S) begin
               all_diff = 1'b1;
               foreach (hist[k]) if (hist[k][b] == m_clean[b]) all_diff = 1'b0;
               if (all_diff) nc[b] = ~m_clean[b];
            end
         end
         m_clean   = nc;
         m_s2      = m_s1;
         m_s1      = i_sw_raw;
         e.clean   = m_clean;
         e.rise    = m_clean & ~old_clean;
         e.fall    = ~m_clean & old_clean;
         e.changed = |(e.rise | e.fall);
      end
      exp_q.push_back(e);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // Monitor: the DUT presents a fresh output word every cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("scoreboard", {19'd0, o_sw_clean, o_sw_rise, o_sw_fall, o_sw_changed}, {19'd0, e});
         end
      end
   end

   // Drive one edge's worth of inputs; returns 2 ns after that edge.
   task automatic cyc(input logic [W-1:0] raw, input logic rst);
      i_sw_raw = raw;
      reset    = rst;
      @(posedge clk);
      #2;
   endtask

   task automatic hold(input logic [W-1:0] raw, input int n);
      for (int k = 0; k < n; k++) cyc(raw, 1'b0);
   endtask

   initial begin
      logic [W-1:0] cur;
      logic [W-1:0] drv;
      logic         bad;
      int           len;

      i_sw_raw = '0;
      reset    = 1'b1;

      // Reset, then clean rising step on bit 0.
      cyc(4'h0, 1'b1);
      cyc(4'h0, 1'b1);
      chk("reset_clean", 32'(o_sw_clean), 32'h0);
      chk("reset_pulses", {29'd0, o_sw_rise != 0, o_sw_fall != 0, o_sw_changed}, 32'h0);
      hold(4'h1, 5);
      chk("step_before", 32'(o_sw_clean), 32'h0);
      cyc(4'h1, 1'b0);
      chk("step_clean", 32'(o_sw_clean), 32'h1);
      chk("step_rise", 32'(o_sw_rise), 32'h1);
      chk("step_fall", 32'(o_sw_fall), 32'h0);
      chk("step_changed", 32'(o_sw_changed), 32'h1);
      cyc(4'h1, 1'b0);
      chk("step_rise_end", {27'd0, o_sw_rise, o_sw_changed}, 32'h0);

      // Bounce rejection on bit 0.
      hold(4'h0, 8);
      chk("bounce_start", 32'(o_sw_clean), 32'h0);
      bad = 1'b0;
      for (int i = 0; i < 100; i++) begin
         cyc({3'b000, (i % 4) != 3}, 1'b0);
         if (o_sw_clean != 0 || o_sw_rise != 0 || o_sw_fall != 0 || o_sw_changed) bad = 1'b1;
      end
      chk("bounce_quiet", 32'(bad), 32'h0);

      // Falling edge on bit 2 from all-ones.
      hold(4'hF, 8);
      chk("fall_start", 32'(o_sw_clean), 32'hF);
      hold(4'hB, 5);
      chk("fall_before", 32'(o_sw_clean), 32'hF);
      cyc(4'hB, 1'b0);
      chk("fall_clean", 32'(o_sw_clean), 32'hB);
      chk("fall_pulse", 32'(o_sw_fall), 32'h4);
      chk("fall_norise", 32'(o_sw_rise), 32'h0);
      cyc(4'hB, 1'b0);
      chk("fall_end", 32'(o_sw_fall), 32'h0);

      // Simultaneous change on bits 1 and 3.
      hold(4'h0, 8);
      chk("sim_start", 32'(o_sw_clean), 32'h0);
      hold(4'hA, 5);
      chk("sim_before", 32'(o_sw_clean), 32'h0);
      cyc(4'hA, 1'b0);
      chk("sim_clean", 32'(o_sw_clean), 32'hA);
      chk("sim_rise", 32'(o_sw_rise), 32'hA);
      chk("sim_changed", 32'(o_sw_changed), 32'h1);
      cyc(4'hA, 1'b0);
      chk("sim_changed_end", 32'(o_sw_changed), 32'h0);

      // Reset while bit 2's counter holds 2.
      hold(4'h0, 8);
      hold(4'h4, 4);
      cyc(4'h4, 1'b1);
      chk("midrst_during", {24'd0, o_sw_clean, o_sw_rise}, 32'h0);
      cyc(4'h4, 1'b0);
      chk("midrst_after", 32'(o_sw_clean), 32'h0);
      hold(4'h4, 4);
      chk("midrst_before", 32'(o_sw_clean), 32'h0);
      cyc(4'h4, 1'b0);
      chk("midrst_clean", 32'(o_sw_clean), 32'h4);
      chk("midrst_rise", 32'(o_sw_rise), 32'h4);
      cyc(4'h4, 1'b0);
      chk("midrst_rise_end", 32'(o_sw_rise), 32'h0);

      // Switches held high through reset.
      cyc(4'hF, 1'b1);
      cyc(4'hF, 1'b1);
      chk("pwr_reset", 32'(o_sw_clean), 32'h0);
      hold(4'hF, 5);
      chk("pwr_before", 32'(o_sw_clean), 32'h0);
      cyc(4'hF, 1'b0);
      chk("pwr_clean", 32'(o_sw_clean), 32'hF);
      chk("pwr_rise", 32'(o_sw_rise), 32'hF);
      cyc(4'hF, 1'b0);
      chk("pwr_rise_end", 32'(o_sw_rise), 32'h0);

      // Randomized levels with glitches and occasional resets.
      cur = '0;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 2) != 0) cur = W'($urandom);
         len = $urandom_range(1, 8);
         for (int k = 0; k < len; k++) begin
            drv = cur;
            if ($urandom_range(0, 5) == 0) drv[$urandom_range(0, W - 1)] ^= 1'b1;
            cyc(drv, (k == 0) && ($urandom_range(0, 40) == 0));
         end
      end

      cyc(cur, 1'b0);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
